itrx_aib_phy_io_buf_tx_dist: RTL and testbench
==============================================

Name: itrx_aib_phy_io_buf_tx_dist

Overview:
- TX-side distribution logic of an AIB buffer; the transmit counterpart of the RX distribution block.
- Retimes SDR/DDR core data onto outclk_dist for the TX serializer: dat0 on the rising edge, dat1 re-launched on the falling edge.
- Passes the async data path inverted toward the ubump driver.
- Sequences enable/disable through a warmup/drain FSM so the bump never sees partial or stale data.

Parameters:
- WARMUP_CYC, 4: outclk_dist cycles of forced-0 output after tx_en rises before data passes (legal range ≥1).
- DRAIN_CYC, 2: forced-0 cycles after tx_en falls before returning to IDLE (legal range ≥1).
- CNT_W, 4: width of the shared warmup/drain counter; must hold max(WARMUP_CYC, DRAIN_CYC).

Ports:
- outclk_dist  in  1  TX retime clock (only clock)
- txd_irstb  in  1  reset, asynchronous, active-low
- tx_en  in  1  transmit enable (level, outclk_dist domain)
- ddr_mode  in  1  1=DDR (dat0+dat1), 0=SDR (dat0 only); static while tx_en=1
- async_en  in  1  enables async path
- idat0  in  1  TX data, first half / SDR
- idat1  in  1  TX data, second half (DDR)
- idat_asyn  in  1  TX async data from core
- ubump_tx_0q  out  1  dat0 retimed, posedge launch
- ubump_tx_1qn  out  1  dat1 retimed, negedge launch
- ubump_tx_n  out  1  async data to analog driver (inverted)
- tx_ready  out  1  high while data passes through (ACTIVE)

Behaviour:
- Reset (txd_irstb=0, async): state=IDLE, counter=0, all retime flops 0. Outputs are ubump_tx_0q=0, ubump_tx_1qn=0, tx_ready=0. ubump_tx_n follows its async rule.
- Reset deassertion mid-operation restarts from IDLE; no data is replayed.
- FSM, evaluated on posedge outclk_dist:
  - IDLE: stays in IDLE while tx_en=0. On tx_en=1, load counter=WARMUP_CYC-1 and go to WARMUP.
  - WARMUP: decrement the counter. At 0 with tx_en=1, go to ACTIVE. If tx_en=0 at any point, load DRAIN_CYC-1 and go to DRAIN.
  - ACTIVE: tx_ready=1. On tx_en=0, load DRAIN_CYC-1 and go to DRAIN.
  - DRAIN: decrement the counter. At 0, go to IDLE. tx_en re-asserting during DRAIN does not abort it; IDLE then sees tx_en=1 and enters WARMUP the next cycle.
- tx_ready is registered and equals (state==ACTIVE).
- dat0 path: d0_q <= (next_state==ACTIVE) ? idat0 : 0 on posedge, and ubump_tx_0q=d0_q. Latency is 1 posedge; the first valid data is idat0 sampled on the same edge where tx_ready rises.
- dat1 path:
  - d1_p <= (next_state==ACTIVE && ddr_mode) ? idat1 : 0 on posedge.
  - d1_n <= d1_p on negedge (also cleared by txd_irstb); ubump_tx_1qn=d1_n.
  - Latency is 1.5 cycles from idat1 sample (half a cycle after ubump_tx_0q).
  - SDR: ubump_tx_1qn held 0.
- Disable: on the posedge where tx_en=0 is seen in ACTIVE, d0_q/d1_p load 0. The bump drives 0 from that edge (1qn from the following negedge).
- Async path: ubump_tx_n = async_en ? ~idat_asyn : 1'b1. Combinational, independent of FSM and reset (idle level is logic 0 on the bump).
- Counter: unsigned, CNT_W bits, loads/decrements only in WARMUP/DRAIN and never wraps. Held at 0 in IDLE/ACTIVE.
- ddr_mode change while ACTIVE is illegal. The design takes the new value at the next posedge, with no glitch beyond one corrupted bit.

Decomposition:
- Shared package itrx_aib_phy_pkg (or existing defines file):
  - state encodings TX_IDLE=2'd0, TX_WARMUP=2'd1, TX_ACTIVE=2'd2, TX_DRAIN=2'd3
  - default WARMUP_CYC/DRAIN_CYC constants
- Sub-module itrx_aib_phy_io_buf_tx_seq: FSM plus counter. Outputs next_state-derived pass enable and tx_ready.
- Retime flops are instances of the existing stdcell DFF. Add a negedge-DFF stdcell wrapper if one is not present.

Test Plan:
- Reset then tx_en=1 at cycle 0, WARMUP_CYC=4, DDR, idat0/1 toggling -> 0q and 1qn stay 0 for posedges 1-4. tx_ready=1 and 0q=idat0 from posedge 5. 1qn=idat1 (posedge-5 sample) at negedge 5.
- SDR (ddr_mode=0), ACTIVE, idat1=1 constantly -> ubump_tx_1qn=0 throughout; 0q tracks idat0 with 1-cycle latency.
- ACTIVE then tx_en=0 at cycle N, DRAIN_CYC=2 -> 0q=0 from posedge N. tx_ready=0 at N. State IDLE after posedge N+2.
- tx_en pulses 1→0→1 within DRAIN -> DRAIN completes (2 cycles), 1 cycle IDLE, then full 4-cycle WARMUP before tx_ready=1.
- txd_irstb asserted asynchronously mid-ACTIVE -> all outputs except ubump_tx_n go 0 immediately without a clock. After release with tx_en=1, WARMUP restarts.
- async_en=0: ubump_tx_n=1 for any idat_asyn. async_en=1, idat_asyn=1 -> ubump_tx_n=0 immediately, including during reset.

Source files
------------

// File: rtl/itrx_aib_phy_io_buf_tx_dist_pkg.sv
// Shared encodings and default timing constants for the AIB TX distribution slice.
package itrx_aib_phy_io_buf_tx_dist_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_WARMUP = 2'd1,
        TX_ACTIVE = 2'd2,
        TX_DRAIN  = 2'd3
    } tx_state_e;

    localparam int unsigned WARMUP_CYC_DEF = 32'd4;
    localparam int unsigned DRAIN_CYC_DEF  = 32'd2;
    localparam int unsigned CNT_W_DEF      = 32'd4;

endpackage

// File: rtl/itrx_aib_phy_io_buf_tx_dist_if.sv
// Core-side TX bundle: enables and data in, bump-side retimed/async data and ready out.
interface itrx_aib_phy_io_buf_tx_dist_if;

    logic tx_en;
    logic ddr_mode;
    logic async_en;
    logic idat0;
    logic idat1;
    logic idat_asyn;
    logic ubump_tx_0q;
    logic ubump_tx_1qn;
    logic ubump_tx_n;
    logic tx_ready;

    modport master (
        output tx_en, ddr_mode, async_en, idat0, idat1, idat_asyn,
        input  ubump_tx_0q, ubump_tx_1qn, ubump_tx_n, tx_ready
    );

    modport slave (
        input  tx_en, ddr_mode, async_en, idat0, idat1, idat_asyn,
        output ubump_tx_0q, ubump_tx_1qn, ubump_tx_n, tx_ready
    );

endinterface

// File: rtl/itrx_aib_phy_io_buf_tx_dist_dff.sv
// Resettable retime flop cell; NEG_EDGE selects falling-edge launch.
module itrx_aib_phy_io_buf_tx_dist_dff #(
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic q_r;

    generate
        if (NEG_EDGE) begin : g_neg
            // Falling-edge capture with async clear
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r <= 1'b0;
                end else begin
                    q_r <= d;
                end
            end
        end else begin : g_pos
            // Rising-edge capture with async clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r <= 1'b0;
                end else begin
                    q_r <= d;
                end
            end
        end
    endgenerate

    assign q = q_r;

endmodule

// File: rtl/itrx_aib_phy_io_buf_tx_dist_seq.sv
// Warmup/drain sequencer: gates data onto the bump only once the path is settled.
module itrx_aib_phy_io_buf_tx_dist_seq
    import itrx_aib_phy_io_buf_tx_dist_pkg::*;
#(
    parameter int unsigned WARMUP_CYC = WARMUP_CYC_DEF,
    parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_en,
    output logic pass_en_s,
    output logic tx_ready_r
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WARMUP_LD = CNT_W'(WARMUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 32'd1);

    tx_state_e        state_r;
    tx_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // State, counter and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= TX_IDLE;
            cnt_r      <= CNT_ZERO;
            tx_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            tx_ready_r <= (state_nxt_s == TX_ACTIVE);
        end
    end

    // Next-state and counter update; the counter only moves in WARMUP/DRAIN and stops at zero
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            TX_IDLE: begin
                if (tx_en) begin
                    state_nxt_s = TX_WARMUP;
                    cnt_nxt_s   = WARMUP_LD;
                end else begin
                    state_nxt_s = TX_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            TX_WARMUP: begin
                if (!tx_en) begin
                    state_nxt_s = TX_DRAIN;
                    cnt_nxt_s   = DRAIN_LD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = TX_ACTIVE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = TX_WARMUP;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            TX_ACTIVE: begin
                if (!tx_en) begin
                    state_nxt_s = TX_DRAIN;
                    cnt_nxt_s   = DRAIN_LD;
                end else begin
                    state_nxt_s = TX_ACTIVE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            TX_DRAIN: begin
                // A re-asserted tx_en is deliberately ignored until IDLE is reached
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = TX_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = TX_DRAIN;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign pass_en_s = (state_nxt_s == TX_ACTIVE);

endmodule

// File: rtl/itrx_aib_phy_io_buf_tx_dist.sv
// AIB TX distribution: retimes dat0 (rise) / dat1 (fall) onto outclk_dist behind a warmup/drain gate.
module itrx_aib_phy_io_buf_tx_dist
    import itrx_aib_phy_io_buf_tx_dist_pkg::*;
#(
    parameter int unsigned WARMUP_CYC = WARMUP_CYC_DEF,
    parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input logic                              outclk_dist,
    input logic                              txd_irstb,
    itrx_aib_phy_io_buf_tx_dist_if.slave     tx_if
);

    logic pass_en_s;
    logic tx_ready_r;
    logic d0_d_s;
    logic d1p_d_s;
    logic d0_q_s;
    logic d1p_q_s;
    logic d1n_q_s;

    itrx_aib_phy_io_buf_tx_dist_seq #(
        .WARMUP_CYC (WARMUP_CYC),
        .DRAIN_CYC  (DRAIN_CYC),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk        (outclk_dist),
        .rst_n      (txd_irstb),
        .tx_en      (tx_if.tx_en),
        .pass_en_s  (pass_en_s),
        .tx_ready_r (tx_ready_r)
    );

    // Gating uses next_state so the first valid bit launches on the edge tx_ready rises
    assign d0_d_s  = pass_en_s ? tx_if.idat0 : 1'b0;
    assign d1p_d_s = (pass_en_s && tx_if.ddr_mode) ? tx_if.idat1 : 1'b0;

    itrx_aib_phy_io_buf_tx_dist_dff #(.NEG_EDGE(1'b0)) u_d0_q (
        .clk   (outclk_dist),
        .rst_n (txd_irstb),
        .d     (d0_d_s),
        .q     (d0_q_s)
    );

    itrx_aib_phy_io_buf_tx_dist_dff #(.NEG_EDGE(1'b0)) u_d1_p (
        .clk   (outclk_dist),
        .rst_n (txd_irstb),
        .d     (d1p_d_s),
        .q     (d1p_q_s)
    );

    itrx_aib_phy_io_buf_tx_dist_dff #(.NEG_EDGE(1'b1)) u_d1_n (
        .clk   (outclk_dist),
        .rst_n (txd_irstb),
        .d     (d1p_q_s),
        .q     (d1n_q_s)
    );

    assign tx_if.ubump_tx_0q  = d0_q_s;
    assign tx_if.ubump_tx_1qn = d1n_q_s;
    assign tx_if.tx_ready     = tx_ready_r;
    // Async path bypasses reset entirely; a disabled path parks the bump at logic 0
    assign tx_if.ubump_tx_n   = tx_if.async_en ? ~tx_if.idat_asyn : 1'b1;

endmodule

// File: tb/tb_itrx_aib_phy_io_buf_tx_dist.sv
// Directed bench for the AIB TX distribution block (WARMUP_CYC=4, DRAIN_CYC=2).
module tb_itrx_aib_phy_io_buf_tx_dist;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] pat0;
    logic [3:0] pat1;

    itrx_aib_phy_io_buf_tx_dist_if tx_if ();

    itrx_aib_phy_io_buf_tx_dist dut (
        .outclk_dist (clk),
        .txd_irstb   (rst_n),
        .tx_if       (tx_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One cycle: check 0q/ready after the posedge, then 1qn after the following negedge
    task automatic step(input string tag, input logic e0, input logic er, input logic e1);
        @(posedge clk);
        #1;
        check_eq({tag, "_0q"}, tx_if.ubump_tx_0q, e0);
        check_eq({tag, "_rdy"}, tx_if.tx_ready, er);
        @(negedge clk);
        #1;
        check_eq({tag, "_1qn"}, tx_if.ubump_tx_1qn, e1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat0 = 4'b1011;
        pat1 = 4'b0110;
        rst_n = 1'b0;
        tx_if.tx_en = 1'b0;
        tx_if.ddr_mode = 1'b1;
        tx_if.async_en = 1'b0;
        tx_if.idat0 = 1'b0;
        tx_if.idat1 = 1'b0;
        tx_if.idat_asyn = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_0q", tx_if.ubump_tx_0q, 1'b0);
        check_eq("rst_1qn", tx_if.ubump_tx_1qn, 1'b0);
        check_eq("rst_rdy", tx_if.tx_ready, 1'b0);
        tx_if.idat_asyn = 1'b1;
        #1;
        check_eq("rst_async_off", tx_if.ubump_tx_n, 1'b1);
        tx_if.async_en = 1'b1;
        #1;
        check_eq("rst_async_on1", tx_if.ubump_tx_n, 1'b0);
        tx_if.idat_asyn = 1'b0;
        #1;
        check_eq("rst_async_on0", tx_if.ubump_tx_n, 1'b1);
        tx_if.async_en = 1'b0;

        // DDR warmup: four gated posedges, data on the fifth
        rst_n = 1'b1;
        tx_if.tx_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tx_if.idat0 = k[0];
            tx_if.idat1 = ~k[0];
            step("warm", 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tx_if.idat0 = pat0[i];
            tx_if.idat1 = pat1[i];
            step("ddr", pat0[i], 1'b1, pat1[i]);
        end

        // Async reset while ACTIVE clears outputs without a clock edge
        tx_if.idat0 = 1'b1;
        tx_if.idat1 = 1'b1;
        step("pre_rst", 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        tx_if.async_en = 1'b1;
        tx_if.idat_asyn = 1'b1;
        #1;
        check_eq("arst_0q", tx_if.ubump_tx_0q, 1'b0);
        check_eq("arst_1qn", tx_if.ubump_tx_1qn, 1'b0);
        check_eq("arst_rdy", tx_if.tx_ready, 1'b0);
        check_eq("arst_async", tx_if.ubump_tx_n, 1'b0);
        tx_if.async_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("arst_hold_0q", tx_if.ubump_tx_0q, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step("rewarm", 1'b0, 1'b0, 1'b0);
        step("reactive", 1'b1, 1'b1, 1'b1);

        // Disable: bump forced to 0 from the edge that sees tx_en low
        tx_if.tx_en = 1'b0;
        for (int k = 0; k < 3; k++) step("dis", 1'b0, 1'b0, 1'b0);

        // SDR: dat1 held at 0 regardless of idat1
        tx_if.ddr_mode = 1'b0;
        tx_if.idat1 = 1'b1;
        tx_if.tx_en = 1'b1;
        for (int k = 0; k < 4; k++) step("sdr_warm", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tx_if.idat0 = pat0[i];
            step("sdr", pat0[i], 1'b1, 1'b0);
        end

        // tx_en drops for one cycle: full drain, one IDLE cycle, full warmup
        tx_if.idat0 = 1'b1;
        tx_if.tx_en = 1'b0;
        step("pulse", 1'b0, 1'b0, 1'b0);
        tx_if.tx_en = 1'b1;
        for (int k = 0; k < 6; k++) step("pulse_gap", 1'b0, 1'b0, 1'b0);
        step("pulse_act", 1'b1, 1'b1, 1'b0);

        // tx_en dropping inside WARMUP diverts to DRAIN
        tx_if.tx_en = 1'b0;
        for (int k = 0; k < 3; k++) step("abort_idle", 1'b0, 1'b0, 1'b0);
        tx_if.tx_en = 1'b1;
        step("abort_w", 1'b0, 1'b0, 1'b0);
        tx_if.tx_en = 1'b0;
        step("abort_d", 1'b0, 1'b0, 1'b0);
        tx_if.tx_en = 1'b1;
        for (int k = 0; k < 6; k++) step("abort_gap", 1'b0, 1'b0, 1'b0);
        step("abort_act", 1'b1, 1'b1, 1'b0);

        // Async path outside reset
        tx_if.async_en = 1'b0;
        tx_if.idat_asyn = 1'b0;
        #1;
        check_eq("async_off0", tx_if.ubump_tx_n, 1'b1);
        tx_if.idat_asyn = 1'b1;
        #1;
        check_eq("async_off1", tx_if.ubump_tx_n, 1'b1);
        tx_if.async_en = 1'b1;
        #1;
        check_eq("async_on1", tx_if.ubump_tx_n, 1'b0);
        tx_if.idat_asyn = 1'b0;
        #1;
        check_eq("async_on0", tx_if.ubump_tx_n, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
